// File: rtl/vga_display_ctrl.sv
// rtl/vga_display_ctrl.sv - 640x480@60 VGA raster timing with pipeline-aligned sync, blank and RGB
module vga_display_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        activeArea,
  output logic        startOfFrame,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hSync,
  output logic        vSync,
  output logic        blankN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0]       hCnt;
  logic [10:0]       vCnt;
  logic              raw_h;
  logic              raw_v;
  logic              raw_active;
  logic [PIPE_LAT:0] h_dly;
  logic [PIPE_LAT:0] v_dly;
  logic [PIPE_LAT:0] act_dly;

  // Raster counters: hCnt every clock, vCnt steps on the same edge hCnt wraps
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hCnt == H_MAX) begin
      hCnt <= '0;
      vCnt <= (vCnt == V_MAX) ? '0 : vCnt + 11'd1;
    end else begin
      hCnt <= hCnt + 11'd1;
    end
  end

  // Undelayed sync/active decode of the current coordinate
  always_comb begin
    raw_h      = !((hCnt >= HS_BEG) && (hCnt <= HS_END));
    raw_v      = !((vCnt >= VS_BEG) && (vCnt <= VS_END));
    raw_active = (hCnt < H_ACT) && (vCnt < V_ACT);
  end

  // Delay lines; reset fills every stage with idle values so refill emits no sync or pixel
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_dly   <= '1;
      v_dly   <= '1;
      act_dly <= '0;
    end else begin
      h_dly   <= {h_dly[PIPE_LAT-1:0], raw_h};
      v_dly   <= {v_dly[PIPE_LAT-1:0], raw_v};
      act_dly <= {act_dly[PIPE_LAT-1:0], raw_active};
    end
  end

  // Colour register: stage PIPE_LAT-1 is the active bit of the pixel RGBIn belongs to now
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (act_dly[PIPE_LAT-1]) begin
      red   <= {RGBIn[7:5], RGBIn[7]};
      green <= {RGBIn[4:2], RGBIn[4]};
      blue  <= {RGBIn[1:0], RGBIn[1:0]};
    end else begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end
  end

  assign pixelX       = hCnt;
  assign pixelY       = vCnt;
  assign activeArea   = raw_active;
  assign startOfFrame = (hCnt == 11'd0) && (vCnt == V_ACT);
  assign hSync        = h_dly[PIPE_LAT];
  assign vSync        = v_dly[PIPE_LAT];
  assign blankN       = act_dly[PIPE_LAT];

endmodule

// File: tb/tb_vga_display_ctrl.sv
// tb/tb_vga_display_ctrl.sv - directed self-checking bench for vga_display_ctrl
module tb_vga_display_ctrl;

  logic clk = 1'b0;
  logic rst_main;
  logic rst_small;
  logic use_fixed;

  logic [7:0]  rgb1, rgb3, rgbs;
  logic [7:0]  mux1_q;
  logic [7:0]  mux3_q [3];

  logic [10:0] px1, py1, px3, py3, pxs, pys;
  logic        aa1, aa3, aas, sof1, sof3, sofs;
  logic [3:0]  r1, g1, b1, r3, g3, b3, rs, gs, bs;
  logic        hs1, vs1, bn1, hs3, vs3, bn3, hss, vss, bns;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Object-mux model: PIPE_LAT register stages, white only at (100,50)
  always @(posedge clk) begin
    mux1_q    <= (px1 == 11'd100 && py1 == 11'd50) ? 8'hFF : 8'h00;
    mux3_q[0] <= (px3 == 11'd100 && py3 == 11'd50) ? 8'hFF : 8'h00;
    mux3_q[1] <= mux3_q[0];
    mux3_q[2] <= mux3_q[1];
  end

  assign rgb1 = use_fixed ? 8'b101_010_11 : mux1_q;
  assign rgb3 = mux3_q[2];
  assign rgbs = 8'b101_010_11;

  vga_display_ctrl #(.PIPE_LAT(1)) u_lat1 (
    .clk(clk), .resetN(rst_main), .RGBIn(rgb1), .pixelX(px1), .pixelY(py1),
    .activeArea(aa1), .startOfFrame(sof1), .red(r1), .green(g1), .blue(b1),
    .hSync(hs1), .vSync(vs1), .blankN(bn1));

  vga_display_ctrl #(.PIPE_LAT(3)) u_lat3 (
    .clk(clk), .resetN(rst_main), .RGBIn(rgb3), .pixelX(px3), .pixelY(py3),
    .activeArea(aa3), .startOfFrame(sof3), .red(r3), .green(g3), .blue(b3),
    .hSync(hs3), .vSync(vs3), .blankN(bn3));

  // Short-frame instance (8 lines) so whole frames fit in a short run
  vga_display_ctrl #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_LAT(1)) u_small (
    .clk(clk), .resetN(rst_small), .RGBIn(rgbs), .pixelX(pxs), .pixelY(pys),
    .activeArea(aas), .startOfFrame(sofs), .red(rs), .green(gs), .blue(bs),
    .hSync(hss), .vSync(vss), .blankN(bns));

  task automatic test_reset();
    rst_main = 1'b0; rst_small = 1'b0; use_fixed = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (px1 !== 11'd0 || py1 !== 11'd0) begin errors++; $display("FAIL reset_counters: x=%0d y=%0d required 0 0", px1, py1); end
    checks++; if (hs1 !== 1'b1 || vs1 !== 1'b1) begin errors++; $display("FAIL reset_sync: h=%b v=%b required 1 1", hs1, vs1); end
    checks++; if (bn1 !== 1'b0) begin errors++; $display("FAIL reset_blank: blankN=%b required 0", bn1); end
    checks++; if ({r1, g1, b1} !== 12'h000) begin errors++; $display("FAIL reset_rgb: rgb=%h required 000", {r1, g1, b1}); end
    checks++; if (hs3 !== 1'b1 || vs3 !== 1'b1 || bn3 !== 1'b0) begin errors++; $display("FAIL reset_lat3: h=%b v=%b bn=%b required 1 1 0", hs3, vs3, bn3); end
    checks++; if (sof1 !== 1'b0 || aa1 !== 1'b1) begin errors++; $display("FAIL reset_sof_active: sof=%b active=%b required 0 1", sof1, aa1); end
    rst_main = 1'b1;
    @(negedge clk);
    checks++; if (px1 !== 11'd1 || py1 !== 11'd0) begin errors++; $display("FAIL release_first: x=%0d y=%0d required 1 0", px1, py1); end
    checks++; if (px3 !== 11'd1) begin errors++; $display("FAIL release_first_lat3: x=%0d required 1", px3); end
  endtask

  task automatic test_hsync();
    int t656 = -1, fall1 = -1, rise1 = -1, fall1b = -1, fall3 = -1;
    logic prev1 = 1'b1, prev3 = 1'b1;
    for (int c = 0; c < 1800; c++) begin
      @(negedge clk);
      if (px1 == 11'd656 && t656 < 0) t656 = c;
      if (prev1 && !hs1) begin
        if (fall1 < 0) fall1 = c;
        else if (fall1b < 0) fall1b = c;
      end
      if (!prev1 && hs1 && fall1 >= 0 && rise1 < 0) rise1 = c;
      if (prev3 && !hs3 && fall3 < 0) fall3 = c;
      prev1 = hs1; prev3 = hs3;
    end
    checks++; if (t656 < 0 || fall1 < 0 || fall1 - t656 != 2) begin errors++; $display("FAIL hsync_delay: fall=%0d x656=%0d required offset 2", fall1, t656); end
    checks++; if (rise1 < 0 || rise1 - fall1 != 96) begin errors++; $display("FAIL hsync_width: %0d required 96", rise1 - fall1); end
    checks++; if (fall1b < 0 || fall1b - fall1 != 800) begin errors++; $display("FAIL hsync_period: %0d required 800", fall1b - fall1); end
    checks++; if (fall3 < 0 || fall3 - t656 != 4) begin errors++; $display("FAIL hsync_delay_lat3: fall=%0d x656=%0d required offset 4", fall3, t656); end
  endtask

  task automatic test_color();
    int vis = 0;
    bit found = 1'b0;
    use_fixed = 1'b1;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (px1 == 11'd0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL color_sync_wait: x=%0d required 0", px1); end
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++;
      if (bn1) begin
        vis++;
        if ({r1, g1, b1} !== 12'hB4F) begin errors++; $display("FAIL color_visible: x=%0d rgb=%h required B4F", px1, {r1, g1, b1}); end
      end else begin
        if ({r1, g1, b1} !== 12'h000) begin errors++; $display("FAIL color_blank: x=%0d rgb=%h required 000", px1, {r1, g1, b1}); end
      end
    end
    checks++; if (vis != 640) begin errors++; $display("FAIL color_visible_count: %0d required 640", vis); end
  endtask

  task automatic test_latency();
    int tpx = -1, hit1 = -1, hit3 = -1, nhit1 = 0, nhit3 = 0, bad1 = 0, bad3 = 0;
    use_fixed = 1'b0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 45000 && py1 != 11'd52; c++) begin
      @(negedge clk);
      if (px1 == 11'd100 && py1 == 11'd50) tpx = c;
      if (bn1 && {r1, g1, b1} == 12'hFFF) begin nhit1++; hit1 = c; end
      else if ({r1, g1, b1} != 12'h000) bad1++;
      if (bn3 && {r3, g3, b3} == 12'hFFF) begin nhit3++; hit3 = c; end
      else if ({r3, g3, b3} != 12'h000) bad3++;
    end
    checks++; if (py1 !== 11'd52) begin errors++; $display("FAIL latency_timeout: y=%0d required 52", py1); end
    checks++; if (nhit1 != 1) begin errors++; $display("FAIL lat1_hits: %0d required 1", nhit1); end
    checks++; if (bad1 != 0) begin errors++; $display("FAIL lat1_stray: %0d required 0", bad1); end
    checks++; if (tpx < 0 || hit1 - tpx != 2) begin errors++; $display("FAIL lat1_offset: %0d required 2", hit1 - tpx); end
    checks++; if (nhit3 != 1) begin errors++; $display("FAIL lat3_hits: %0d required 1", nhit3); end
    checks++; if (bad3 != 0) begin errors++; $display("FAIL lat3_stray: %0d required 0", bad3); end
    checks++; if (tpx < 0 || hit3 - tpx != 4) begin errors++; $display("FAIL lat3_offset: %0d required 4", hit3 - tpx); end
  endtask

  task automatic test_frame();
    int vf [2], vr [2], sp [2];
    int nvf = 0, nvr = 0, nsp = 0, bad_sof = 0;
    logic prev = 1'b1;
    for (int i = 0; i < 2; i++) begin vf[i] = -1; vr[i] = -1; sp[i] = -1; end
    rst_small = 1'b1;
    for (int c = 0; c < 14000; c++) begin
      @(negedge clk);
      if (prev && !vss) begin if (nvf < 2) vf[nvf] = c; nvf++; end
      if (!prev && vss) begin if (nvr < 2) vr[nvr] = c; nvr++; end
      if (sofs) begin
        if (nsp < 2) sp[nsp] = c;
        nsp++;
        if (pxs !== 11'd0 || pys !== 11'd4) bad_sof++;
      end
      prev = vss;
    end
    checks++; if (nvf != 2) begin errors++; $display("FAIL vsync_count: %0d required 2", nvf); end
    checks++; if (vf[1] - vf[0] != 6400) begin errors++; $display("FAIL vsync_period: %0d required 6400", vf[1] - vf[0]); end
    checks++; if (nvr != 2 || vr[0] - vf[0] != 1600) begin errors++; $display("FAIL vsync_width0: %0d required 1600", vr[0] - vf[0]); end
    checks++; if (nvr != 2 || vr[1] - vf[1] != 1600) begin errors++; $display("FAIL vsync_width1: %0d required 1600", vr[1] - vf[1]); end
    checks++; if (nsp != 2) begin errors++; $display("FAIL sof_count: %0d required 2", nsp); end
    checks++; if (sp[1] - sp[0] != 6400) begin errors++; $display("FAIL sof_period: %0d required 6400", sp[1] - sp[0]); end
    checks++; if (bad_sof != 0) begin errors++; $display("FAIL sof_position: %0d bad pulses required 0", bad_sof); end
    checks++; if (vf[0] - sp[0] != 802) begin errors++; $display("FAIL sof_to_vsync: %0d required 802", vf[0] - sp[0]); end
  endtask

  task automatic test_reset_mid_sync();
    bit found = 1'b0;
    int t656 = -1, fall = -1, vs_low = 0;
    logic prev = 1'b1;
    for (int c = 0; c < 8000 && !found; c++) begin
      @(negedge clk);
      if (pxs == 11'd700 && pys == 11'd5) found = 1'b1;
    end
    checks++; if (!found || hss !== 1'b0 || vss !== 1'b0) begin errors++; $display("FAIL midsync_pre: found=%b h=%b v=%b required 1 0 0", found, hss, vss); end
    rst_small = 1'b0;
    #1;
    checks++; if (hss !== 1'b1 || vss !== 1'b1) begin errors++; $display("FAIL midsync_async: h=%b v=%b required 1 1", hss, vss); end
    checks++; if (pxs !== 11'd0 || pys !== 11'd0 || bns !== 1'b0) begin errors++; $display("FAIL midsync_state: x=%0d y=%0d bn=%b required 0 0 0", pxs, pys, bns); end
    repeat (3) @(negedge clk);
    rst_small = 1'b1;
    for (int c = 0; c < 1700; c++) begin
      @(negedge clk);
      if (pxs == 11'd656 && t656 < 0) t656 = c;
      if (prev && !hss && fall < 0) fall = c;
      if (!vss) vs_low++;
      prev = hss;
    end
    checks++; if (t656 < 0 || fall < 0 || fall - t656 != 2) begin errors++; $display("FAIL midsync_first_hsync: fall=%0d x656=%0d required offset 2", fall, t656); end
    checks++; if (vs_low != 0) begin errors++; $display("FAIL midsync_vsync_quiet: %0d low cycles required 0", vs_low); end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_color();
    test_latency();
    test_frame();
    test_reset_mid_sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
